// File: rtl/cnn_pipe_pkg.sv
// Shared types and helpers for the CNN datapath pipeline delay line.
package cnn_pipe_pkg;

  localparam int unsigned CH_W       = 8;
  localparam int unsigned NUM_CH_DEF = 4;

  // Default-configuration multi-channel word, ch0 in the LSBs.
  typedef logic [NUM_CH_DEF-1:0][CH_W-1:0] ch_word_t;

  typedef struct packed {
    logic        err;
    logic [31:0] value;
  } clamp_t;

  function automatic int unsigned dly_w(input int unsigned max_depth);
    return $clog2(max_depth + 1);
  endfunction

  // Clamp a requested latency into 1..max_dly, flagging any adjustment.
  function automatic clamp_t clamp_dly(input logic [31:0] req, input logic [31:0] max_dly);
    clamp_t r;
    r.err   = 1'b0;
    r.value = req;
    if (req == 32'd0) begin
      r.err   = 1'b1;
      r.value = 32'd1;
    end else if (req > max_dly) begin
      r.err   = 1'b1;
      r.value = max_dly;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the delay line: valid bit plus channel data.
module pipe_stage #(
  parameter int unsigned W = 33
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_delay_line.sv
// Multi-channel register chain with runtime latency, stall, valid tagging and flush.
module pipe_delay_line
  import cnn_pipe_pkg::*;
#(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MAX_DEPTH   = 16,
  parameter int unsigned DEFAULT_DLY = 1,
  localparam int unsigned DLY_W      = dly_w(MAX_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        cfg_load,
  input  logic [DLY_W-1:0]            cfg_delay,
  input  logic [NUM_CH*DataWidth-1:0] din,
  input  logic                        din_valid,
  output logic [NUM_CH*DataWidth-1:0] dout,
  output logic                        dout_valid,
  output logic                        busy,
  output logic [DLY_W-1:0]            cur_dly,
  output logic                        cfg_err
);

  localparam int unsigned WORD_W  = NUM_CH * DataWidth;
  localparam int unsigned STAGE_W = WORD_W + 1;

  logic               clear;
  logic [STAGE_W-1:0] stage_d [MAX_DEPTH];
  logic [STAGE_W-1:0] stage_q [MAX_DEPTH];
  logic [STAGE_W-1:0] sel;
  logic               any_valid;
  clamp_t             clamp_res;

  // A new latency invalidates everything in flight, so cfg_load also clears.
  assign clear = flush | cfg_load;

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = {din_valid, din};
    end else begin : g_body
      assign stage_d[k] = stage_q[k-1];
    end

    pipe_stage #(.W(STAGE_W)) u_stage (
      .CLK (CLK),
      .RST (RST),
      .clr (clear),
      .en  (en),
      .d   (stage_d[k]),
      .q   (stage_q[k])
    );
  end

  always_comb begin
    clamp_res = clamp_dly(32'(cfg_delay), 32'(MAX_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_dly <= DLY_W'(DEFAULT_DLY);
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      cur_dly <= DLY_W'(clamp_res.value);
      cfg_err <= cfg_err | clamp_res.err;
    end
  end

  // Output tap at cur_dly-1; busy only looks at the stages in the active window.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
      if (DLY_W'(k + 1) == cur_dly) begin
        sel = stage_q[k];
      end
      if (DLY_W'(k) < cur_dly) begin
        any_valid = any_valid | stage_q[k][STAGE_W-1];
      end
    end
  end

  assign dout       = sel[WORD_W-1:0];
  assign dout_valid = sel[STAGE_W-1];
  assign busy       = any_valid;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed, table-driven check of pipe_delay_line latency, stall, flush and config handling.
module tb_pipe_delay_line;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  logic        flush;
  logic        cfg_load;
  logic [4:0]  cfg_delay;
  logic [31:0] din;
  logic        din_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;
  logic [4:0]  cur_dly;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        flush;
    logic        ld;
    logic [4:0]  cd;
    logic [31:0] din;
    logic        dv;
    logic [31:0] e_dout;
    logic        e_v;
    logic        e_busy;
    logic [4:0]  e_cur;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  pipe_delay_line #(
    .DataWidth   (8),
    .NUM_CH      (4),
    .MAX_DEPTH   (16),
    .DEFAULT_DLY (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .flush      (flush),
    .cfg_load   (cfg_load),
    .cfg_delay  (cfg_delay),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .cur_dly    (cur_dly),
    .cfg_err    (cfg_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_dout, input logic e_v,
                           input logic e_busy, input logic [4:0] e_cur, input logic e_err);
    check({tag, ".dout"}, dout, e_dout);
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_v));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".cur_dly"}, 32'(cur_dly), 32'(e_cur));
    check({tag, ".cfg_err"}, 32'(cfg_err), 32'(e_err));
  endtask

  function automatic void add(input logic e, input logic f, input logic l, input logic [4:0] c,
                              input logic [31:0] d, input logic v, input logic [31:0] ed,
                              input logic ev, input logic eb, input logic [4:0] ec, input logic ee);
    vec_t t;
    t.en = e; t.flush = f; t.ld = l; t.cd = c; t.din = d; t.dv = v;
    t.e_dout = ed; t.e_v = ev; t.e_busy = eb; t.e_cur = ec; t.e_err = ee;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic e, input logic f, input logic l, input logic [4:0] c,
                       input logic [31:0] d, input logic v);
    en = e; flush = f; cfg_load = l; cfg_delay = c; din = d; din_valid = v;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    RST = 1'b1;
    tick();
    tick();
    check_all("reset", 32'h0, 1'b0, 1'b0, 5'd1, 1'b0);
    RST = 1'b0;

    // Columns: en flush ld cd din dv | dout valid busy cur err (after the edge)
    // Delay 3 streaming; the word presented with cfg_load is dropped.
    add(1, 0, 1, 5'd3, 32'hDEADBEEF, 1, 32'h0,        0, 0, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h11111111, 1, 32'h0,        0, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h22222222, 1, 32'h0,        0, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h33333333, 1, 32'h11111111, 1, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h44444444, 1, 32'h22222222, 1, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h33333333, 1, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h44444444, 1, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 0, 5'd3, 0);
    // Stall: word A then two en=0 cycles; din during stall ignored.
    add(1, 0, 0, 5'd0, 32'hAAAAAAAA, 1, 32'h0,        0, 1, 5'd3, 0);
    add(0, 0, 0, 5'd0, 32'hBBBBBBBB, 1, 32'h0,        0, 1, 5'd3, 0);
    add(0, 0, 0, 5'd0, 32'hBBBBBBBB, 1, 32'h0,        0, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'hAAAAAAAA, 1, 1, 5'd3, 0);
    add(0, 0, 0, 5'd0, 32'hCCCCCCCC, 1, 32'hAAAAAAAA, 1, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 0, 5'd3, 0);
    // Four words in flight, then flush with a word that must be dropped.
    add(1, 0, 0, 5'd0, 32'h01010101, 1, 32'h0,        0, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h02020202, 1, 32'h0,        0, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h03030303, 1, 32'h01010101, 1, 1, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h04040404, 1, 32'h02020202, 1, 1, 5'd3, 0);
    add(1, 1, 0, 5'd0, 32'h55555555, 1, 32'h0,        0, 0, 5'd3, 0);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 0, 5'd3, 0);
    // Config clamping: 0 -> 1, 20 -> 16, 16 in range but error stays sticky.
    add(1, 0, 1, 5'd0,  32'h0,       0, 32'h0,        0, 0, 5'd1,  1);
    add(1, 0, 1, 5'd20, 32'h0,       0, 32'h0,        0, 0, 5'd16, 1);
    add(1, 0, 1, 5'd16, 32'h0,       0, 32'h0,        0, 0, 5'd16, 1);
    // cfg_load + flush + en with valid din: latch 2, clear, drop din.
    add(1, 1, 1, 5'd2, 32'h77777777, 1, 32'h0,        0, 0, 5'd2, 1);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 0, 5'd2, 1);
    add(1, 0, 0, 5'd0, 32'h66666666, 1, 32'h0,        0, 1, 5'd2, 1);
    add(1, 0, 0, 5'd0, 32'h0,        0, 32'h66666666, 1, 1, 5'd2, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].flush, vecs[i].ld, vecs[i].cd, vecs[i].din, vecs[i].dv);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_v, vecs[i].e_busy,
                vecs[i].e_cur, vecs[i].e_err);
    end

    // Reset mid-stream at delay 8, then default latency after release.
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 1'b0);
    tick();
    check("rst_seq.cur8", 32'(cur_dly), 32'd8);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'(i + 1) * 32'h01000001, 1'b1);
      tick();
    end
    check("rst_seq.busy_inflight", 32'(busy), 32'd1);
    check("rst_seq.valid_inflight", 32'(dout_valid), 32'd0);
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h12345678, 1'b1);
    tick();
    check_all("rst_seq.after_rst", 32'h0, 1'b0, 1'b0, 5'd1, 1'b0);
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h99999999, 1'b1);
    tick();
    check_all("rst_seq.dly1_word", 32'h99999999, 1'b1, 1'b1, 5'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    check_all("rst_seq.dly1_empty", 32'h0, 1'b0, 1'b0, 5'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
